// File: rtl/io_periph.sv
// io_periph: memory-mapped IO block with an LED register, a FIFO-backed
// 8N1 UART transmitter and a UART status/control register.
module io_periph #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16,
    parameter int LED_W        = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [31:0]      IO_mem_addr,
    input  logic [31:0]      IO_mem_wdata,
    input  logic             IO_mem_wr,
    output logic [31:0]      IO_mem_rdata,
    output logic [LED_W-1:0] leds,
    output logic             uart_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_CNT    = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Register decode
    logic [2:0] sel;
    logic       wr_led, wr_data, wr_stat;
    assign sel     = IO_mem_addr[4:2];
    assign wr_led  = IO_mem_wr && (sel == 3'd0);
    assign wr_data = IO_mem_wr && (sel == 3'd1);
    assign wr_stat = IO_mem_wr && (sel == 3'd2);

    // Only address bits [4:2] and part of the store data are decoded
    logic unused_ok;
    assign unused_ok = ^{IO_mem_addr[31:5], IO_mem_addr[1:0], IO_mem_wdata};

    // FIFO state
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          fifo_full, fifo_empty, push, pop, overflow;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    // A push into a full FIFO is dropped even if the serializer pops on the
    // same edge; the status count was full when the store was issued.
    assign push       = wr_data && !fifo_full;

    // Serializer state
    state_t        state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          tx_n;

    // LED register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     leds <= '0;
        else if (wr_led) leds <= IO_mem_wdata[LED_W-1:0];
    end

    // FIFO storage (contents need no reset; pointers/count gate validity)
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= IO_mem_wdata[7:0];
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag; a new overflow wins over a same-cycle clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                            overflow <= 1'b0;
        else if (wr_data && fifo_full)          overflow <= 1'b1;
        else if (wr_stat && IO_mem_wdata[3])    overflow <= 1'b0;
    end

    // Serializer state register; uart_tx is registered from the next level
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            uart_tx <= tx_n;
        end
    end

    // Serializer next state; tx_n is the line level for the coming cycle
    always_comb begin
        state_n   = state;
        baud_n    = baud;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        tx_n      = 1'b1;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rptr];
                    state_n = START;
                    baud_n  = BAUD_RELOAD;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (baud == '0) begin
                    state_n   = DATA;
                    bit_idx_n = 3'd0;
                    baud_n    = BAUD_RELOAD;
                    tx_n      = shift[0];
                end else begin
                    baud_n = baud - BW'(1);
                end
            end
            DATA: begin
                tx_n = shift[0];
                if (baud == '0) begin
                    shift_n = {1'b0, shift[7:1]};
                    baud_n  = BAUD_RELOAD;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = shift[1];
                    end
                end else begin
                    baud_n = baud - BW'(1);
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (baud == '0) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit
                        pop     = 1'b1;
                        shift_n = mem[rptr];
                        state_n = START;
                        baud_n  = BAUD_RELOAD;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                        baud_n  = '0;
                    end
                end else begin
                    baud_n = baud - BW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                baud_n  = '0;
            end
        endcase
    end

    // Combinational read mux; reads have no side effects
    always_comb begin
        IO_mem_rdata = '0;
        case (sel)
            3'd0: IO_mem_rdata = 32'(leds);
            3'd2: IO_mem_rdata = {16'h0, 8'(count), 4'h0, overflow,
                                  (state != IDLE), fifo_full, fifo_empty};
            default: IO_mem_rdata = '0;
        endcase
    end
endmodule
